// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter sharing one register-file write port among NREQ requesters.
// Optional macro WB_BYPASS_EN enables forwarding of the output-stage write to the decode reads.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      reqValid,
  input  logic [NREQ*AW-1:0]   reqAddr,
  input  logic [NREQ*DW-1:0]   reqData,
  output logic [NREQ-1:0]      reqReady,
  output logic                 regWrite,
  output logic [AW-1:0]        writeAddr,
  output logic [DW-1:0]        writeData,
  output logic [1:0]           grantId,
  output logic [(2**AW)-1:0]   pendingMask,
  input  logic [AW-1:0]        readAddr1,
  input  logic [AW-1:0]        readAddr2,
  output logic                 fwdHit1,
  output logic                 fwdHit2,
  output logic [DW-1:0]        fwdData1,
  output logic [DW-1:0]        fwdData2
);

  logic [NREQ-1:0] hold_valid_q, hold_valid_d;
  logic [AW-1:0]   hold_addr_q [NREQ];
  logic [AW-1:0]   hold_addr_d [NREQ];
  logic [DW-1:0]   hold_data_q [NREQ];
  logic [DW-1:0]   hold_data_d [NREQ];

  logic [1:0]      last_grant_q;
  logic [1:0]      winner;
  logic            win_valid;

  logic            reg_write_q;
  logic [AW-1:0]   write_addr_q;
  logic [DW-1:0]   write_data_q;
  logic [1:0]      grant_id_q;

  // Walk from the farthest candidate to the nearest so the nearest non-empty hold wins.
  always_comb begin
    win_valid = 1'b0;
    winner    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      int idx;
      idx = int'(last_grant_q) + k;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      if (hold_valid_q[idx]) begin
        win_valid = 1'b1;
        winner    = 2'(idx);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      reqReady[i] = ~hold_valid_q[i] | (win_valid & (winner == 2'(i)));
    end
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    for (int i = 0; i < NREQ; i++) begin
      hold_addr_d[i] = hold_addr_q[i];
      hold_data_d[i] = hold_data_q[i];
      if (win_valid && (winner == 2'(i))) hold_valid_d[i] = 1'b0;
      // Writes to r0 are acknowledged but dropped; the hold stays empty.
      if (reqValid[i] && reqReady[i] && (reqAddr[i*AW +: AW] != '0)) begin
        hold_valid_d[i] = 1'b1;
        hold_addr_d[i]  = reqAddr[i*AW +: AW];
        hold_data_d[i]  = reqData[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        hold_addr_q[i] <= '0;
        hold_data_q[i] <= '0;
      end
    end else begin
      hold_valid_q <= hold_valid_d;
      for (int i = 0; i < NREQ; i++) begin
        hold_addr_q[i] <= hold_addr_d[i];
        hold_data_q[i] <= hold_data_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 2'(NREQ - 1);
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      grant_id_q   <= '0;
    end else begin
      reg_write_q <= win_valid;
      if (win_valid) begin
        last_grant_q <= winner;
        write_addr_q <= hold_addr_q[winner];
        write_data_q <= hold_data_q[winner];
        grant_id_q   <= winner;
      end
    end
  end

  assign regWrite  = reg_write_q;
  assign writeAddr = write_addr_q;
  assign writeData = write_data_q;
  assign grantId   = grant_id_q;

  always_comb begin
    pendingMask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (hold_valid_q[i]) pendingMask[hold_addr_q[i]] = 1'b1;
    end
    if (reg_write_q) pendingMask[write_addr_q] = 1'b1;
  end

`ifdef WB_BYPASS_EN
  assign fwdHit1  = reg_write_q & (write_addr_q == readAddr1) & (readAddr1 != '0);
  assign fwdHit2  = reg_write_q & (write_addr_q == readAddr2) & (readAddr2 != '0);
  assign fwdData1 = fwdHit1 ? write_data_q : '0;
  assign fwdData2 = fwdHit2 ? write_data_q : '0;
`else
  logic unused_read;
  assign unused_read = ^{readAddr1, readAddr2};
  assign fwdHit1  = 1'b0;
  assign fwdHit2  = 1'b0;
  assign fwdData1 = '0;
  assign fwdData2 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed literal checks plus randomized traffic
// compared every cycle against a queue/array model of holds and the output stage.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      reqValid;
  logic [NREQ*AW-1:0]   reqAddr;
  logic [NREQ*DW-1:0]   reqData;
  logic [NREQ-1:0]      reqReady;
  logic                 regWrite;
  logic [AW-1:0]        writeAddr;
  logic [DW-1:0]        writeData;
  logic [1:0]           grantId;
  logic [(2**AW)-1:0]   pendingMask;
  logic [AW-1:0]        readAddr1, readAddr2;
  logic                 fwdHit1, fwdHit2;
  logic [DW-1:0]        fwdData1, fwdData2;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqAddr(reqAddr), .reqData(reqData),
    .reqReady(reqReady), .regWrite(regWrite), .writeAddr(writeAddr), .writeData(writeData),
    .grantId(grantId), .pendingMask(pendingMask), .readAddr1(readAddr1),
    .readAddr2(readAddr2), .fwdHit1(fwdHit1), .fwdHit2(fwdHit2), .fwdData1(fwdData1),
    .fwdData2(fwdData2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one slot per requester plus the last issued write.
  bit          m_hv [NREQ];
  logic [AW-1:0] m_ha [NREQ];
  logic [DW-1:0] m_hd [NREQ];
  int          m_last;
  bit          m_rw;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  int          m_gid;

  function automatic int m_winner();
    for (int k = 1; k <= NREQ; k++) begin
      int idx = (m_last + k) % NREQ;
      if (m_hv[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_hv[i] = 0; m_ha[i] = '0; m_hd[i] = '0;
    end
    m_last = NREQ - 1;
    m_rw = 0; m_wa = '0; m_wd = '0; m_gid = 0;
  endtask

  task automatic m_step();
    int w;
    bit rdy;
    if (!rst_n) return;
    w = m_winner();
    if (w >= 0) begin
      m_rw = 1; m_wa = m_ha[w]; m_wd = m_hd[w]; m_gid = w; m_last = w;
    end else begin
      m_rw = 0;
    end
    for (int i = 0; i < NREQ; i++) begin
      rdy = !m_hv[i] || (w == i);
      if (w == i) m_hv[i] = 0;
      if (reqValid[i] && rdy && reqAddr[i*AW +: AW] != 0) begin
        m_hv[i] = 1;
        m_ha[i] = reqAddr[i*AW +: AW];
        m_hd[i] = reqData[i*DW +: DW];
      end
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    int w;
    logic [NREQ-1:0] e_rdy;
    logic [(2**AW)-1:0] e_pm;
    bit e_h1, e_h2;
    w = m_winner();
    e_pm = '0;
    for (int i = 0; i < NREQ; i++) begin
      e_rdy[i] = !m_hv[i] || (w == i);
      if (m_hv[i]) e_pm[m_ha[i]] = 1'b1;
    end
    if (m_rw) e_pm[m_wa] = 1'b1;
`ifdef WB_BYPASS_EN
    e_h1 = m_rw && (m_wa == readAddr1) && (readAddr1 != 0);
    e_h2 = m_rw && (m_wa == readAddr2) && (readAddr2 != 0);
`else
    e_h1 = 0;
    e_h2 = 0;
`endif
    chk("m_reqReady", 64'(reqReady), 64'(e_rdy));
    chk("m_regWrite", 64'(regWrite), 64'(m_rw));
    chk("m_writeAddr", 64'(writeAddr), 64'(m_wa));
    chk("m_writeData", 64'(writeData), 64'(m_wd));
    chk("m_grantId", 64'(grantId), 64'(m_gid));
    chk("m_pendingMask", 64'(pendingMask), 64'(e_pm));
    chk("m_fwdHit1", 64'(fwdHit1), 64'(e_h1));
    chk("m_fwdHit2", 64'(fwdHit2), 64'(e_h2));
    chk("m_fwdData1", 64'(fwdData1), e_h1 ? 64'(m_wd) : 64'd0);
    chk("m_fwdData2", 64'(fwdData2), e_h2 ? 64'(m_wd) : 64'd0);
  end

  task automatic step();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    reqValid[i] = v;
    reqAddr[i*AW +: AW] = a;
    reqData[i*DW +: DW] = d;
  endtask

  int gseq[$];
  int exp_g;

  initial begin
    rst_n = 1'b0;
    m_reset();
    readAddr1 = '0; readAddr2 = '0;
    reqValid = '0; reqAddr = '0; reqData = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1, AW'(i + 1), DW'(32'h100 + i));

    // Reset with all requesters valid.
    step(); step();
    @(negedge clk);
    chk("rst_regWrite", 64'(regWrite), 64'd0);
    chk("rst_pendingMask", 64'(pendingMask), 64'd0);
    chk("rst_reqReady", 64'(reqReady), 64'h7);
    chk("rst_grantId", 64'(grantId), 64'd0);

    // Fairness: continuously valid, grants rotate and ready rotates one-hot.
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      @(negedge clk);
      if (regWrite) gseq.push_back(int'(grantId));
      chk("fair_reqReady", 64'(reqReady), 64'(3'b001 << ((k - 1) % 3)));
    end
    for (int j = 0; j < 6; j++) begin
      exp_g = j % 3;
      chk("fair_grant", (j < gseq.size()) ? 64'(gseq[j]) : 64'hdead, 64'(exp_g));
    end
    step();
    reqValid = '0;
    repeat (5) step();

    // Single write r5 from requester 1, with a decode read on r5.
    set_req(1, 1, 5'd5, 32'hDEADBEEF);
    readAddr1 = 5'd5;
    step();
    reqValid = '0;
    @(negedge clk);
    chk("sw_pending5", 64'(pendingMask[5]), 64'd1);
    chk("sw_noWriteYet", 64'(regWrite), 64'd0);
    step();
    @(negedge clk);
    chk("sw_regWrite", 64'(regWrite), 64'd1);
    chk("sw_writeAddr", 64'(writeAddr), 64'd5);
    chk("sw_writeData", 64'(writeData), 64'hDEADBEEF);
    chk("sw_grantId", 64'(grantId), 64'd1);
`ifdef WB_BYPASS_EN
    chk("sw_fwdHit1", 64'(fwdHit1), 64'd1);
    chk("sw_fwdData1", 64'(fwdData1), 64'hDEADBEEF);
`else
    chk("sw_fwdHit1", 64'(fwdHit1), 64'd0);
`endif
    step();
    @(negedge clk);
    chk("sw_pendingClear", 64'(pendingMask), 64'd0);
    chk("sw_pulse", 64'(regWrite), 64'd0);
    readAddr1 = '0;

    // Reset while holds are full: nothing is written afterwards.
    for (int i = 0; i < NREQ; i++) set_req(i, 1, AW'(8 + i), DW'(32'hA0 + i));
    step();
    reqValid = '0;
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    chk("rstfull_pending", 64'(pendingMask), 64'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("rstfull_noWrite", 64'(regWrite), 64'd0);
    end

    // Conflict on r7 right after reset: requester 0 first, then 2.
    set_req(0, 1, 5'd7, 32'h11);
    set_req(2, 1, 5'd7, 32'h22);
    step();
    reqValid = '0;
    @(negedge clk);
    chk("cf_pending7a", 64'(pendingMask[7]), 64'd1);
    step();
    @(negedge clk);
    chk("cf_first", 64'(writeData), 64'h11);
    chk("cf_pending7b", 64'(pendingMask[7]), 64'd1);
    step();
    @(negedge clk);
    chk("cf_second", 64'(writeData), 64'h22);
    chk("cf_pending7c", 64'(pendingMask[7]), 64'd1);
    step();
    @(negedge clk);
    chk("cf_pendingClear", 64'(pendingMask), 64'd0);

    // Register 0 write is acknowledged and dropped.
    set_req(0, 1, 5'd0, 32'hFFFF);
    @(negedge clk);
    chk("r0_ready", 64'(reqReady[0]), 64'd1);
    step();
    reqValid = '0;
    @(negedge clk);
    chk("r0_pending", 64'(pendingMask), 64'd0);
    step();
    @(negedge clk);
    chk("r0_noWrite", 64'(regWrite), 64'd0);

    // Random traffic with occasional resets; narrow address range forces collisions and r0.
    for (int c = 0; c < 600; c++) begin
      step();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 79) == 0) begin
        rst_n = 1'b0;
        m_reset();
      end
      for (int i = 0; i < NREQ; i++)
        set_req(i, ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)), DW'($urandom));
      readAddr1 = AW'($urandom_range(0, 7));
      readAddr2 = AW'($urandom_range(0, 7));
    end
    step();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (regWrite/writeAddr/writeData) among NREQ writeback requesters, e.g. ALU result, load data and link address.
- Each requester has a one-entry holding register with a valid/ready handshake.
- A round-robin arbiter drains the holds into a registered output stage that drives the register file directly.
- Exports a pending-write mask so the controller can stall on register hazards.

Parameters:
- NREQ, 3, number of requesters (2..4)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- reqValid  in  NREQ  requester i offers a write
- reqAddr  in  NREQ*AW  destination register; slice i = [i*AW +: AW]
- reqData  in  NREQ*DW  write data; slice i = [i*DW +: DW]
- reqReady  out  NREQ  requester i's offer is accepted this edge
- regWrite  out  1  register-file write enable
- writeAddr  out  AW  register-file write address
- writeData  out  DW  register-file write data
- grantId  out  2  index of requester that produced the current output write
- pendingMask  out  2**AW  bit r set = a write to register r is held or on the output stage
- readAddr1, readAddr2  in  AW  decode read addresses (used by the optional feature)
- fwdHit1, fwdHit2  out  1  forward-hit flags
- fwdData1, fwdData2  out  DW  forwarded data

Behaviour:
- Reset (async, rst_n=0):
  - all holds empty; regWrite=0, writeAddr=0, writeData=0, grantId=0, pendingMask=0.
  - RR pointer lastGrant=NREQ-1, so requester 0 has first priority.
  - Reset mid-operation discards held writes; no partial write is issued.
- Handshake:
  - reqReady[i] = hold[i] empty OR hold[i] granted this cycle (combinational, never depends on reqValid).
  - Transfer occurs when reqValid[i] & reqReady[i] at a rising edge; hold[i] loads addr/data.
  - Simultaneous grant and new accept on the same requester: the hold is replaced, no bubble.
- Register 0: a transfer with addr 0 is accepted (reqReady as normal) but never loaded. It produces no write and no pending bit.
- Arbitration, combinational each cycle:
  - Search order is lastGrant+1, lastGrant+2, … modulo NREQ; the first non-empty hold wins.
  - At the next edge the winner's addr/data go to the output stage with regWrite=1 and grantId=winner; its hold clears unless reloaded; lastGrant=winner.
  - No winner: regWrite=0 at that edge; writeAddr/writeData hold their previous value.
- Latency: accept at edge E → regWrite high in the cycle after edge E+1 at the earliest. Throughput is one write per cycle total.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,0,…; no requester waits more than NREQ-1 grants.
- Same register from several requesters: writes are issued in grant order, so the last granted value wins in the register file.
- pendingMask: OR of the one-hot decode of every non-empty hold and of writeAddr when regWrite=1. Registered-state derived, glitch-free relative to clk.
- regWrite is a single-cycle pulse per granted write; it never remains high without a new grant.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - fwdHitN = regWrite & (writeAddr==readAddrN) & (readAddrN!=0).
  - fwdDataN = writeData when fwdHitN, else 0 (combinational).
  - This covers the read-during-write case of the combinational register file.
- Undefined: fwdHit1/2 and fwdData1/2 tied to 0; ports remain present.

Test Plan:
- Reset: hold rst_n=0 with reqValid=3'b111 → regWrite=0, pendingMask=0, reqReady=3'b111. Release; first grantId=0.
- Single write:
  - Req1 writes r5=0xDEADBEEF at edge E → pendingMask[5]=1 after E; regWrite=1, writeAddr=5, writeData=0xDEADBEEF, grantId=1 after E+1.
  - pendingMask=0 one cycle later.
- Fairness: all three valid every cycle, addresses 1/2/3 → grantId sequence 0,1,2,0,1,2 and each reqReady high exactly once per 3 cycles after the first fill.
- Conflict: req0 r7=0x11 and req2 r7=0x22 in the same cycle → two writes, 0x11 then 0x22; pendingMask[7] stays 1 until the second write leaves.
- Register 0: req0 writes r0=0xFFFF → reqReady[0]=1, no regWrite pulse, pendingMask=0.
- Bypass and reset:
  - With WB_BYPASS_EN, readAddr1=5 during the r5 write → fwdHit1=1, fwdData1=0xDEADBEEF.
  - Without the macro, same stimulus → fwdHit1=0.
  - Assert rst_n low while holds are full → no write issued after release.
